cache_line_fill_controller: RTL and testbench

- Sequences the shared memory port on behalf of whichever cache the memory arbiter has granted.
- Turns one line-fill request into WORDS_PER_LINE pipelined word reads, critical word first, against a fixed-latency memory.
- Streams the returned words into the cache data array and signals completion.
- Also performs single-word write-through stores.

---
 rtl/cache_line_fill_controller.sv | 142 ++++++++++++++
 tb/tb_cache_line_fill_controller.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_line_fill_controller.sv
// Line-fill and write-through sequencer for the shared memory port: critical-word-first
// pipelined word reads against fixed-latency memory, plus single-word stores.
module cache_line_fill_controller #(
  parameter int unsigned MEM_LATENCY    = 4,
  parameter int unsigned WORDS_PER_LINE = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              req,
  input  logic                              req_we,
  input  logic [15:0]                       req_addr,
  input  logic [15:0]                       req_wdata,
  output logic                              busy,
  output logic                              done,
  output logic                              mem_en,
  output logic                              mem_wr,
  output logic [15:0]                       mem_addr,
  output logic [15:0]                       mem_wdata,
  input  logic [15:0]                       mem_rdata,
  output logic                              fill_we,
  output logic [$clog2(WORDS_PER_LINE)-1:0] fill_word,
  output logic [15:0]                       fill_data
);

  localparam int unsigned LOG2      = $clog2(WORDS_PER_LINE);
  localparam int unsigned LAT       = MEM_LATENCY;
  localparam logic [15:0] LINE_MASK = 16'(2 * WORDS_PER_LINE - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, WRITE, DONE} state_t;

  state_t            state, state_d;
  logic [15:0]       base_q, base_d;
  logic [LOG2-1:0]   word_q, word_d;
  logic [LOG2-1:0]   cnt_q, cnt_d;
  logic [LOG2-1:0]   word_inc;
  logic              busy_d, done_d, mem_en_d, mem_wr_d;
  logic [15:0]       mem_addr_d, mem_wdata_d;
  logic [LAT-1:0]    pipe_v;
  logic [LOG2-1:0]   pipe_w [LAT];
  logic              pipe_busy;
  logic              unused_addr_bit;

  assign word_inc        = word_q + LOG2'(1);
  assign pipe_busy       = |pipe_v;
  assign unused_addr_bit = req_addr[0];

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Next state and next values of the memory-side outputs
  always_comb begin
    state_d     = state;
    base_d      = base_q;
    word_d      = word_q;
    cnt_d       = cnt_q;
    mem_en_d    = 1'b0;
    mem_wr_d    = 1'b0;
    mem_addr_d  = 16'h0000;
    mem_wdata_d = 16'h0000;
    case (state)
      IDLE: begin
        if (req) begin
          base_d     = req_addr & ~LINE_MASK;
          mem_en_d   = 1'b1;
          mem_addr_d = {req_addr[15:1], 1'b0};
          if (req_we) begin
            state_d     = WRITE;
            mem_wr_d    = 1'b1;
            mem_wdata_d = req_wdata;
          end else begin
            state_d = ISSUE;
            word_d  = req_addr[LOG2:1];
            cnt_d   = '0;
          end
        end
      end
      ISSUE: begin
        // Word index wraps inside the line, so the line base never changes
        if (cnt_q == LOG2'(WORDS_PER_LINE - 1)) begin
          state_d = DRAIN;
        end else begin
          mem_en_d   = 1'b1;
          mem_addr_d = base_q | 16'({word_inc, 1'b0});
          word_d     = word_inc;
          cnt_d      = cnt_q + LOG2'(1);
        end
      end
      DRAIN: begin
        if (fill_we && !pipe_busy) state_d = DONE;
      end
      WRITE:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // Output registers, request context and the read-return tracking pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      base_q    <= 16'h0000;
      word_q    <= '0;
      cnt_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_en    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= 16'h0000;
      mem_wdata <= 16'h0000;
      pipe_v    <= '0;
      for (int i = 0; i < LAT; i++) pipe_w[i] <= '0;
      fill_we   <= 1'b0;
      fill_word <= '0;
      fill_data <= 16'h0000;
    end else begin
      base_q    <= base_d;
      word_q    <= word_d;
      cnt_q     <= cnt_d;
      busy      <= busy_d;
      done      <= done_d;
      mem_en    <= mem_en_d;
      mem_wr    <= mem_wr_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      pipe_v[0] <= mem_en & ~mem_wr;
      pipe_w[0] <= word_q;
      for (int i = 1; i < LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_w[i] <= pipe_w[i-1];
      end
      // Last stage lines up with the cycle mem_rdata is valid for that issue
      fill_we   <= pipe_v[LAT-1];
      fill_word <= pipe_v[LAT-1] ? pipe_w[LAT-1] : '0;
      fill_data <= pipe_v[LAT-1] ? mem_rdata : 16'h0000;
    end
  end

endmodule

// File: tb/tb_cache_line_fill_controller.sv
// Bench for cache_line_fill_controller: scoreboard-checked request table plus hand
// sequences for abort, back-to-back and a short-latency/short-line instance.
module tb_cache_line_fill_controller;

  localparam int unsigned L1 = 4;
  localparam int unsigned N1 = 8;

  typedef struct {int cyc; logic [15:0] addr; logic wr; logic [15:0] wdata;} iss_t;
  typedef struct {int cyc; logic [2:0] word; logic [15:0] data;} fill_t;
  typedef struct {logic we; logic [15:0] addr; logic [15:0] wdata; int exp_done;} vec_t;

  logic clk = 1'b0;
  logic rst, req, req_we;
  logic [15:0] req_addr, req_wdata, mem_rdata;
  logic busy, done, mem_en, mem_wr, fill_we;
  logic [15:0] mem_addr, mem_wdata, fill_data;
  logic [2:0] fill_word;

  logic req2, req_we2;
  logic [15:0] req_addr2, req_wdata2, mem_rdata2;
  logic busy2, done2, mem_en2, mem_wr2, fill_we2;
  logic [15:0] mem_addr2, mem_wdata2, fill_data2;
  logic [1:0] fill_word2;

  iss_t  iq[$];
  fill_t fq[$];
  int    dq[$];
  int    cyc = 0;
  int    n_checks = 0;
  int    n_errors = 0;
  int    bfrom = 1;
  int    bto = 0;
  bit    mon_on = 1'b0;
  logic [16:0] hist  [64];
  logic [16:0] hist2 [64];
  logic [16:0] e1, e2;
  vec_t  tbl [5];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cache_line_fill_controller #(.MEM_LATENCY(L1), .WORDS_PER_LINE(N1)) dut (
    .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .busy(busy), .done(done), .mem_en(mem_en), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .fill_we(fill_we), .fill_word(fill_word), .fill_data(fill_data)
  );

  cache_line_fill_controller #(.MEM_LATENCY(1), .WORDS_PER_LINE(4)) dut_s (
    .clk(clk), .rst(rst), .req(req2), .req_we(req_we2), .req_addr(req_addr2),
    .req_wdata(req_wdata2), .busy(busy2), .done(done2), .mem_en(mem_en2), .mem_wr(mem_wr2),
    .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2),
    .fill_we(fill_we2), .fill_word(fill_word2), .fill_data(fill_data2)
  );

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void flag(string name, int at);
    n_checks++;
    n_errors++;
    $display("FAIL %s: event for cycle %0d (now cycle %0d)", name, at, cyc);
  endfunction

  // Fixed-latency memory: read data equals the issued address
  always @(negedge clk) begin
    hist[cyc % 64]  = {mem_en && !mem_wr, mem_addr};
    hist2[cyc % 64] = {mem_en2 && !mem_wr2, mem_addr2};
    e1 = hist[(cyc + 64 - L1) % 64];
    e2 = hist2[(cyc + 63) % 64];
    mem_rdata  = (e1[16] === 1'b1) ? e1[15:0] : 16'h0BAD;
    mem_rdata2 = (e2[16] === 1'b1) ? e2[15:0] : 16'h0BAD;
  end

  // Scoreboard expectations for one accepted request whose cycle 0 is t0
  task automatic start_req(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                           input int t0);
    iss_t ie;
    fill_t fe;
    logic [15:0] base;
    logic [2:0] st, w;
    req = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    bfrom = t0 + 1;
    if (we) begin
      ie.cyc = t0 + 1; ie.addr = {addr[15:1], 1'b0}; ie.wr = 1'b1; ie.wdata = wdata;
      iq.push_back(ie);
      dq.push_back(t0 + 2);
      bto = t0 + 2;
    end else begin
      base = addr & 16'hFFF0;
      st = addr[3:1];
      for (int k = 0; k < int'(N1); k++) begin
        w = st + 3'(k);
        ie.cyc = t0 + 1 + k; ie.addr = base | 16'({w, 1'b0}); ie.wr = 1'b0; ie.wdata = 16'h0;
        iq.push_back(ie);
        fe.cyc = t0 + 2 + k + int'(L1); fe.word = w; fe.data = ie.addr;
        fq.push_back(fe);
      end
      dq.push_back(t0 + int'(L1 + N1) + 2);
      bto = t0 + int'(L1 + N1) + 2;
    end
  endtask

  task automatic flush_from(input int lim);
    iss_t ti[$];
    fill_t tf[$];
    int td[$];
    foreach (iq[i]) if (iq[i].cyc < lim) ti.push_back(iq[i]);
    foreach (fq[i]) if (fq[i].cyc < lim) tf.push_back(fq[i]);
    foreach (dq[i]) if (dq[i] < lim) td.push_back(dq[i]);
    iq = ti; fq = tf; dq = td;
  endtask

  task automatic wait_done(output int d);
    d = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        d = cyc;
        break;
      end
    end
    if (d < 0) flag("done_timeout", cyc);
  endtask

  // Per-cycle monitor, sampled just after the rising edge
  always begin
    @(posedge clk);
    #1;
    if (mon_on) begin
      chk("busy", 32'(busy), 32'(cyc >= bfrom && cyc <= bto));
      while (iq.size() > 0 && iq[0].cyc < cyc) begin flag("missing_issue", iq[0].cyc); iq.delete(0); end
      while (fq.size() > 0 && fq[0].cyc < cyc) begin flag("missing_fill", fq[0].cyc); fq.delete(0); end
      while (dq.size() > 0 && dq[0] < cyc) begin flag("missing_done", dq[0]); dq.delete(0); end
      if (mem_en === 1'b1) begin
        if (iq.size() > 0 && iq[0].cyc == cyc) begin
          chk("mem_addr", 32'(mem_addr), 32'(iq[0].addr));
          chk("mem_wr", 32'(mem_wr), 32'(iq[0].wr));
          chk("mem_wdata", 32'(mem_wdata), 32'(iq[0].wdata));
          iq.delete(0);
        end else flag("unexpected_issue", cyc);
      end else begin
        chk("mem_idle", {15'h0, mem_wr, mem_addr | mem_wdata}, 32'h0);
      end
      if (fill_we === 1'b1) begin
        if (fq.size() > 0 && fq[0].cyc == cyc) begin
          chk("fill_word", 32'(fill_word), 32'(fq[0].word));
          chk("fill_data", 32'(fill_data), 32'(fq[0].data));
          fq.delete(0);
        end else flag("unexpected_fill", cyc);
      end else begin
        chk("fill_idle", {13'h0, fill_word, fill_data}, 32'h0);
      end
      if (done === 1'b1) begin
        if (dq.size() > 0 && dq[0] == cyc) dq.delete(0);
        else flag("unexpected_done", cyc);
      end else begin
        chk("done_low", 32'(done), 32'h0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, d, d2;
    tbl[0] = '{1'b0, 16'h1236, 16'h0000, 14};
    tbl[1] = '{1'b1, 16'h0041, 16'hBEEF, 2};
    tbl[2] = '{1'b0, 16'hFFFE, 16'h0000, 14};
    tbl[3] = '{1'b1, 16'hFFFF, 16'h1234, 2};
    tbl[4] = '{1'b0, 16'h0010, 16'h0000, 14};
    for (int i = 0; i < 64; i++) begin hist[i] = '0; hist2[i] = '0; end
    rst = 1'b1; req = 1'b0; req_we = 1'b0; req_addr = 16'h0; req_wdata = 16'h0;
    req2 = 1'b0; req_we2 = 1'b0; req_addr2 = 16'h0; req_wdata2 = 16'h0;
    mem_rdata = 16'h0; mem_rdata2 = 16'h0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_mem", {15'h0, mem_en, mem_addr | mem_wdata}, 32'h0);
    chk("rst_fill", {12'h0, fill_we, fill_word, fill_data}, 32'h0);
    chk("rst_s", {28'h0, busy2, done2, mem_en2, fill_we2}, 32'h0);
    rst = 1'b0;
    mon_on = 1'b1;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      t0 = cyc;
      start_req(tbl[i].we, tbl[i].addr, tbl[i].wdata, t0);
      wait_done(d);
      chk("done_latency", 32'(d - t0), 32'(tbl[i].exp_done));
      req = 1'b0;
      @(negedge clk);
    end

    // Request inputs wiggle while a fill is in flight
    @(negedge clk);
    t0 = cyc;
    start_req(1'b0, 16'h2000, 16'h0000, t0);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        req_addr = (k % 2 == 1) ? 16'h3000 : 16'h2000;
        req_we = (k == 5 || k == 6);
      end
    end
    req_we = 1'b0; req_addr = 16'h2000;
    wait_done(d);
    chk("toggle_latency", 32'(d - t0), 32'd14);
    req = 1'b0;
    @(negedge clk);

    // Reset in cycle 7 of a fill; memory keeps returning stale data
    @(negedge clk);
    t0 = cyc;
    start_req(1'b0, 16'h0000, 16'h0000, t0);
    repeat (7) @(negedge clk);
    rst = 1'b1; req = 1'b0;
    flush_from(t0 + 8);
    bto = t0 + 7;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    t0 = cyc;
    start_req(1'b0, 16'h0010, 16'h0000, t0);
    wait_done(d);
    chk("post_rst_latency", 32'(d - t0), 32'd14);
    req = 1'b0;
    @(negedge clk);

    // Back-to-back: write then read accepted in the first idle cycle
    @(negedge clk);
    t0 = cyc;
    start_req(1'b1, 16'h0100, 16'h5A5A, t0);
    wait_done(d);
    chk("b2b_write_latency", 32'(d - t0), 32'd2);
    start_req(1'b0, 16'h0100, 16'h0000, d + 1);
    wait_done(d2);
    chk("b2b_read_latency", 32'(d2 - d - 1), 32'd14);
    req = 1'b0;
    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(iq.size() + fq.size() + dq.size()), 32'h0);

    // Latency 1, four-word line, read at 0x0006
    @(negedge clk);
    req2 = 1'b1; req_addr2 = 16'h0006;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      chk("s_busy", 32'(busy2), 32'(k <= 7));
      chk("s_mem_en", 32'(mem_en2), 32'(k <= 4));
      if (k <= 4) chk("s_mem_addr", 32'(mem_addr2), 32'(2 * ((k + 2) % 4)));
      chk("s_fill_we", 32'(fill_we2), 32'(k >= 3 && k <= 6));
      if (k >= 3 && k <= 6) begin
        chk("s_fill_word", 32'(fill_word2), 32'(k % 4));
        chk("s_fill_data", 32'(fill_data2), 32'(2 * (k % 4)));
      end
      chk("s_done", 32'(done2), 32'(k == 7));
      if (k == 7) req2 = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
